// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: per-register pending-write scoreboard and decode interlock; HAZARD_PERF_CNT_EN adds a stall-cycle counter.
module decode_hazard_ctrl #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_flush,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic [4:0]  dec_rd,
  input  logic        dec_wr_enable,
  input  logic        wb_wr_enable,
  input  logic [4:0]  wb_wr_addr,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy_vec,
  output logic        err_underflow
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam logic [PEND_W-1:0] PMAX = '1;
  logic [PEND_W-1:0] pend [32];
  logic haz1, haz2, full, uflow;
  logic [31:0] inc, dec;
  // hazard detection, issue gating and one-hot update strobes; x0 never tracked
  always_comb begin
    haz1 = dec_rs1_used && dec_rs1 != 5'd0 && pend[dec_rs1] != '0;
    haz2 = dec_rs2_used && dec_rs2 != 5'd0 && pend[dec_rs2] != '0;
    full = dec_wr_enable && dec_rd != 5'd0 && pend[dec_rd] == PMAX;
    stall = dec_valid && !dec_flush && (haz1 || haz2 || full);
    issue = dec_valid && !dec_flush && !stall;
    inc = (issue && dec_wr_enable && dec_rd != 5'd0) ? 32'd1 << dec_rd : 32'd0;
    dec = (wb_wr_enable && wb_wr_addr != 5'd0) ? 32'd1 << wb_wr_addr : 32'd0;
    busy_vec = 32'd0;
    for (int r = 1; r < 32; r++) busy_vec[r] = pend[r] != '0;
    uflow = |(dec & ~inc & ~busy_vec);
  end
  // pending counters: simultaneous issue and writeback cancel; writeback at zero flags underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++)
        if (inc[r] && !dec[r]) pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && !inc[r] && pend[r] != '0) pend[r] <= pend[r] - 1'b1;
      if (uflow) err_underflow <= 1'b1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  // free-running stall-cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) perf_stall_cnt <= 32'd0;
    else if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: scoreboard bench with directed scenarios and randomized traffic against a counting model.
module tb_decode_hazard_ctrl;
  localparam int PW = 2;
  localparam int MAXC = (1 << PW) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid = 0, dec_flush = 0, dec_rs1_used = 0, dec_rs2_used = 0, dec_wr_enable = 0, wb_wr_enable = 0;
  logic [4:0] dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0, wb_wr_addr = 0;
  logic stall, issue, err_underflow;
  logic [31:0] busy_vec, perf_stall_cnt;
  always #5 clk = ~clk;

  decode_hazard_ctrl #(.PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_flush(dec_flush),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_wr_enable(dec_wr_enable), .wb_wr_enable(wb_wr_enable), .wb_wr_addr(wb_wr_addr),
    .stall(stall), .issue(issue), .busy_vec(busy_vec), .err_underflow(err_underflow)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );
`ifndef HAZARD_PERF_CNT_EN
  assign perf_stall_cnt = 32'd0;
`endif

  typedef struct {logic st; logic is; logic err; logic [31:0] busy; logic [31:0] perf;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int mp[32];
  bit merr;
  int unsigned mperf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: compare the oldest expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, e.st});
      chk("issue", {31'd0, issue}, {31'd0, e.is});
      chk("busy_vec", busy_vec, e.busy);
      chk("err_underflow", {31'd0, err_underflow}, {31'd0, e.err});
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, e.perf);
`endif
    end
  end

  task automatic step(input bit r, input bit v, input bit f, input int s1, input bit u1, input int s2,
                      input bit u2, input int d, input bit w, input bit wb, input int wa);
    exp_t e;
    bit h, iss;
    rst = r; dec_valid = v; dec_flush = f; dec_rs1 = 5'(s1); dec_rs1_used = u1;
    dec_rs2 = 5'(s2); dec_rs2_used = u2; dec_rd = 5'(d); dec_wr_enable = w;
    wb_wr_enable = wb; wb_wr_addr = 5'(wa);
    h = (u1 && s1 != 0 && mp[s1] > 0) || (u2 && s2 != 0 && mp[s2] > 0) || (w && d != 0 && mp[d] == MAXC);
    e.st = v && !f && h;
    iss = v && !f && !h;
    e.is = iss;
    for (int i = 0; i < 32; i++) e.busy[i] = mp[i] > 0;
    e.err = merr;
    e.perf = mperf;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (mp[i]) mp[i] = 0;
      merr = 0;
      mperf = 0;
    end else begin
      if (e.st) mperf++;
      if (wb && wa != 0 && !(iss && w && d == wa)) begin
        if (mp[wa] > 0) mp[wa]--;
        else merr = 1;
      end
      if (iss && w && d != 0 && !(wb && wa == d)) mp[d]++;
    end
    #1;
  endtask

  task automatic idle(input bit wb, input int wa);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, wb, wa);
  endtask

  initial begin
    foreach (mp[i]) mp[i] = 0;
    merr = 0;
    mperf = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5, 1, 0, 0, 0, 0, i == 2, 5);
    step(0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    idle(1, 5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 7);
    step(0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) idle(1, 7);
    step(0, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, 9);
    idle(1, 9);
    idle(1, 9);
    step(0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    step(0, 1, 1, 4, 1, 0, 0, 4, 1, 0, 0);
    idle(1, 4);
    idle(1, 3);
    idle(0, 0);
    idle(0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    for (int n = 0; n < 2000; n++) begin
      bit wb, rr;
      int wa;
      wb = 0; wa = 0;
      rr = $urandom_range(0, 299) == 0;
      if (!rr && $urandom_range(0, 9) < 6) begin
        for (int t = 0; t < 8 && !wb; t++) begin
          wa = $urandom_range(1, 7);
          wb = mp[wa] > 0;
        end
        if (!wb) wa = 0;
      end else if (!rr && $urandom_range(0, 49) == 0) begin
        wb = 1;
        wa = $urandom_range(0, 31);
      end
      step(rr, $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 9) < 7, wb, wa);
    end
    idle(0, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
